// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the round-robin write arbiter.
// The slave modport is the arbiter's view; the master modport is its environment.
interface fifo_wr_arbiter_if #(
    parameter int DW        = 8,
    parameter int N         = 4,
    parameter int MAX_BURST = 16
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic [DW-1:0]   fifo_din;
    logic            fifo_write;
    logic            grant_vld;
    logic [IW-1:0]   grant_idx;
    logic [CW-1:0]   beat_cnt;

    modport slave (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_din,
        output fifo_write,
        output grant_vld,
        output grant_idx,
        output beat_cnt
    );

    modport master (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_din,
        input  fifo_write,
        input  grant_vld,
        input  grant_idx,
        input  beat_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N valid/ready requesters.
// state   | meaning
// S_IDLE  | no grant; pick next requester after rr_ptr, no transfer
// S_BURST | grant held; beat when granted valid and FIFO not full
module fifo_wr_arbiter #(
    parameter int DW        = 8,
    parameter int N         = 4,
    parameter int MAX_BURST = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_grant_vld;
    logic          w_grant_vld_nxt;
    logic [IW-1:0] r_grant_idx;
    logic [IW-1:0] w_grant_idx_nxt;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] w_rr_ptr_nxt;
    logic [CW-1:0] r_beat_cnt;
    logic [CW-1:0] w_beat_cnt_nxt;
    logic [IW-1:0] w_sel_idx;
    logic          w_sel_found;
    logic          w_gnt_req;
    logic          w_beat;
    logic [N-1:0]  w_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_grant_vld <= 1'b0;
            r_grant_idx <= '0;
            r_beat_cnt  <= '0;
            r_rr_ptr    <= IW'(N - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_grant_vld <= w_grant_vld_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
        end
    end

    // Scan downward so the last hit is the nearest index after rr_ptr.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (bus.req_valid[(int'(r_rr_ptr) + k) % N]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IW'((int'(r_rr_ptr) + k) % N);
            end
        end
    end

    assign w_gnt_req = bus.req_valid[r_grant_idx];
    assign w_beat    = (r_state == S_BURST) && w_gnt_req && !bus.fifo_full && !i_rst;

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_vld_nxt = r_grant_vld;
        w_grant_idx_nxt = r_grant_idx;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_rr_ptr_nxt    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt     = S_BURST;
                    w_grant_vld_nxt = 1'b1;
                    w_grant_idx_nxt = w_sel_idx;
                    w_beat_cnt_nxt  = '0;
                    w_rr_ptr_nxt    = w_sel_idx;
                end
            end
            S_BURST: begin
                if (!w_gnt_req) begin
                    w_state_nxt     = S_IDLE;
                    w_grant_vld_nxt = 1'b0;
                end else if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + CW'(1);
                    if (r_beat_cnt == CW'(MAX_BURST - 1)) begin
                        w_state_nxt     = S_IDLE;
                        w_grant_vld_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_grant_vld_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_ready = '0;
        if (w_beat) begin
            w_ready[r_grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.fifo_write = w_beat;
    assign bus.fifo_din   = r_grant_vld ? bus.req_data[int'(r_grant_idx) * DW +: DW] : '0;
    assign bus.grant_vld  = r_grant_vld;
    assign bus.grant_idx  = r_grant_idx;
    assign bus.beat_cnt   = r_beat_cnt;
endmodule
